// File: rtl/mrd_pkg.sv
// Shared types and helpers for the multi-rate tick divider.
// Priority selector encodings are visible to any block that imports the package.
package mrd_pkg;

    localparam int unsigned MRD_WIDTH = 20;

    typedef enum logic [1:0] {
        SEL_RESTART = 2'd0,
        SEL_RELOAD  = 2'd1,
        SEL_STEP    = 2'd2,
        SEL_HOLD    = 2'd3
    } mrd_sel_e;

    function automatic int unsigned ch_lsb(
        input int unsigned ch,
        input int unsigned width
    );
        return ch * width;
    endfunction

endpackage

// File: rtl/mrd_channel.sv
// One tick channel: counter, shadow divide value latched only at wrap,
// restart or halt, and a registered one-cycle tick.
module mrd_channel
    import mrd_pkg::*;
#(
    parameter int unsigned WIDTH = MRD_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             step_i,
    input  logic             restart_i,
    input  logic [WIDTH-1:0] div_i,
    output logic             tick_o,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dact_q, dact_d;
    logic             tick_q, tick_d;
    mrd_sel_e         sel;

    always_comb begin
        sel = SEL_HOLD;
        if (restart_i) begin
            sel = SEL_RESTART;
        end else if (dact_q == '0) begin
            sel = SEL_RELOAD;
        end else if (step_i) begin
            sel = SEL_STEP;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        dact_d = dact_q;
        tick_d = 1'b0;
        unique case (sel)
            SEL_RESTART, SEL_RELOAD: begin
                cnt_d  = '0;
                dact_d = div_i;
            end
            SEL_STEP: begin
                // dact_q is nonzero here, so cnt_q stays below it
                if (cnt_q == dact_q - WIDTH'(1)) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    dact_d = div_i;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            SEL_HOLD: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            dact_q <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dact_q <= dact_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/multi_rate_divider.sv
// N_CH independent programmable tick generators on one clock.
// Define MRD_PRESCALE_EN to gate all channels with a shared 1-in-PRESCALE strobe.
module multi_rate_divider
    import mrd_pkg::*;
#(
    parameter int unsigned WIDTH    = MRD_WIDTH,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned PRESCALE = 50
) (
    input  logic                  clock_in,
    input  logic                  resetn,
    input  logic [N_CH-1:0]       enable,
    input  logic [N_CH-1:0]       restart,
    input  logic [N_CH*WIDTH-1:0] div_value,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH*WIDTH-1:0] count_out
);

    logic strobe;

    if (N_CH < 1 || PRESCALE < 1) begin : g_param_chk
        $error("multi_rate_divider: N_CH and PRESCALE must be >= 1");
    end

`ifdef MRD_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q, pre_d;

    assign strobe = (pre_q == PW'(PRESCALE - 1));
    assign pre_d  = strobe ? '0 : pre_q + PW'(1);

    // Free-running; only resetn clears it so channel restarts keep phase
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign strobe = 1'b1;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mrd_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk_i    (clock_in),
            .rst_ni   (resetn),
            .step_i   (enable[i] & strobe),
            .restart_i(restart[i]),
            .div_i    (div_value[ch_lsb(i, WIDTH) +: WIDTH]),
            .tick_o   (tick[i]),
            .cnt_o    (count_out[ch_lsb(i, WIDTH) +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed bench for multi_rate_divider with hand-computed expectations.
// With MRD_PRESCALE_EN defined only the prescaled-period scenario runs.
module tb_multi_rate_divider;
    import mrd_pkg::*;

    localparam int unsigned W  = 20;
    localparam int unsigned NC = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [NC-1:0] en;
    logic [NC-1:0] rs;
    logic [NC-1:0] tick;
    logic [NC*W-1:0] div;
    logic [NC*W-1:0] cnt;

    int n_cmp = 0;
    int n_err = 0;

    multi_rate_divider #(
        .WIDTH(W),
        .N_CH(NC),
        .PRESCALE(3)
    ) dut (
        .clock_in (clk),
        .resetn   (rstn),
        .enable   (en),
        .restart  (rs),
        .div_value(div),
        .tick     (tick),
        .count_out(cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int unsigned ch, input int unsigned v);
        div[ch_lsb(ch, W) +: W] = W'(v);
    endtask

    function automatic logic [31:0] cnt_of(input int unsigned ch);
        return 32'(cnt[ch_lsb(ch, W) +: W]);
    endfunction

    task automatic chk_ch(input string tag, input int unsigned ch,
                          input int unsigned ecnt, input logic etick);
        check($sformatf("%s.cnt", tag), cnt_of(ch), ecnt);
        check($sformatf("%s.tick", tag), 32'(tick[ch]), 32'(etick));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        en   = '0;
        rs   = '0;
        div  = '0;
        repeat (2) cyc();
        rstn = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst.tick", 32'(tick), 32'd0);
        check("rst.cnt_lo", cnt[31:0], 32'd0);
        check("rst.cnt_hi", 32'(cnt[NC*W-1:32]), 32'd0);

`ifdef MRD_PRESCALE_EN
        begin
            int found = 0;
            en[0] = 1'b1;
            set_div(0, 2);
            for (int k = 0; k < 20 && found == 0; k++) begin
                cyc();
                if (tick[0]) found = 1;
            end
            check("pre.first_tick", 32'(found), 32'd1);
            for (int k = 1; k <= 12; k++) begin
                cyc();
                check($sformatf("pre.k%0d", k), 32'(tick[0]),
                      32'((k % 6) == 0));
            end
        end
`else
        // ch0, div=3: halt exit then ticks every 3rd edge
        en[0] = 1'b1;
        set_div(0, 3);
        cyc();
        chk_ch("d3.exit", 0, 0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk_ch($sformatf("d3.k%0d", k), 0, k % 3, (k % 3) == 0);
        end

        // ch1, div=1 continuous, then 1->4
        en[1] = 1'b1;
        set_div(1, 1);
        cyc();
        chk_ch("d1.exit", 1, 0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk_ch($sformatf("d1.k%0d", k), 1, 0, 1'b1);
        end
        set_div(1, 4);
        cyc();
        chk_ch("d1to4.last", 1, 0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk_ch($sformatf("d1to4.k%0d", k), 1, k % 4, k == 4);
        end

        // ch2, div=5 changed to 2 at cnt=1
        en[2] = 1'b1;
        set_div(2, 5);
        cyc();
        cyc();
        chk_ch("d5.c1", 2, 1, 1'b0);
        set_div(2, 2);
        for (int k = 2; k <= 5; k++) begin
            cyc();
            chk_ch($sformatf("d5to2.k%0d", k), 2, k % 5, k == 5);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk_ch($sformatf("d2.k%0d", k), 2, k % 2, (k % 2) == 0);
        end

        // restart with wrap due next edge
        set_div(2, 5);
        rs[2] = 1'b1;
        cyc();
        rs[2] = 1'b0;
        chk_ch("rs.load", 2, 0, 1'b0);
        repeat (4) cyc();
        chk_ch("rs.c4", 2, 4, 1'b0);
        rs[2] = 1'b1;
        cyc();
        rs[2] = 1'b0;
        chk_ch("rs.notick", 2, 0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk_ch($sformatf("rs.k%0d", k), 2, k % 5, k == 5);
        end

        // enable held low for 3 cycles mid-period
        repeat (2) cyc();
        chk_ch("en.c2", 2, 2, 1'b0);
        en[2] = 1'b0;
        repeat (3) cyc();
        chk_ch("en.frozen", 2, 2, 1'b0);
        en[2] = 1'b1;
        cyc();
        cyc();
        chk_ch("en.c4", 2, 4, 1'b0);
        cyc();
        chk_ch("en.tick", 2, 0, 1'b1);

        // ch3, div=4 then 0 mid-period: period completes, then halt
        en[3] = 1'b1;
        set_div(3, 4);
        cyc();
        cyc();
        set_div(3, 0);
        cyc();
        cyc();
        chk_ch("h.c3", 3, 3, 1'b0);
        cyc();
        chk_ch("h.lasttick", 3, 0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk_ch($sformatf("h.k%0d", k), 3, 0, 1'b0);
        end

        // async reset mid-period
        set_div(3, 4);
        repeat (3) cyc();
        chk_ch("ar.c2", 3, 2, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check("ar.tick", 32'(tick), 32'd0);
        check("ar.cnt_lo", cnt[31:0], 32'd0);
        check("ar.cnt_hi", 32'(cnt[NC*W-1:32]), 32'd0);

        // all four channels with different divides
        en  = '0;
        div = '0;
        #1;
        rstn = 1'b1;
        for (int unsigned c = 0; c < NC; c++) set_div(c, c + 1);
        en = '1;
        cyc();
        check("ind.exit", 32'(tick), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            logic [NC-1:0] exp_t;
            cyc();
            for (int c = 0; c < NC; c++) exp_t[c] = (k % (c + 1)) == 0;
            check($sformatf("ind.k%0d", k), 32'(tick), 32'(exp_t));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
